alu_exec_stage: RTL and testbench
=================================

# alu_exec_stage

Registered execute stage for the 64-bit ALU datapath. It accepts one operation per cycle over a valid/ready handshake and evaluates ADD, SUB, AND, XOR, SLL, SRL or SRA. The result and per-op flags go into a single output pipeline register; a separate condition-code register (ZF/SF/OF) is updated on request. The stage sits between decode (upstream) and memory/writeback (downstream), and computes SLL with the same 6-bit shift-amount rule as the standalone shifter.

## Interface
Parameters:
- W, 64, datapath width; only 64 is supported.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  upstream operation present
- in_ready  out  1  stage can accept this cycle
- alu_fun  in  3  0 ADD, 1 SUB, 2 AND, 3 XOR, 4 SLL, 5 SRL, 6 SRA, 7 illegal
- in_a  in  64  operand A
- in_b  in  64  operand B; bits [5:0] are the shift amount for ops 4–6
- set_cc  in  1  update the CC register with this op's flags
- out_valid  out  1  output register holds a result
- out_ready  in  1  downstream consumes this cycle
- result  out  64  registered result
- res_zf / res_sf / res_of  out  1 each  registered flags of `result`
- illegal  out  1  registered; the held op had alu_fun = 7
- cc_zf / cc_sf / cc_of  out  1 each  condition-code register

## Operation
- Arithmetic is modulo 2^64.
  - ADD: a + b.
  - SUB: a − b.
  - AND, XOR: bitwise.
  - SLL: a << b[5:0].
  - SRL: logical right shift by b[5:0].
  - SRA: arithmetic right shift by b[5:0], sign-filled from a[63].
  - b[63:6] are ignored for all shifts.
- Flags:
  - ZF = (result == 0).
  - SF = result[63].
  - OF for ADD = a[63]==b[63] && result[63]!=a[63].
  - OF for SUB = a[63]!=b[63] && result[63]!=a[63].
  - OF = 0 for all other ops.
- Illegal op (alu_fun = 7): result = 0, ZF=1, SF=0, OF=0, illegal=1. The CC register is never updated by an illegal op, even if set_cc=1.
- Handshake:
  - Accept = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - in_ready = !flush && (!out_valid || out_ready). This is combinational from out_ready, so an op can be accepted in the same cycle the held one drains.
- Output register:
  - On accept: load result, res_*, illegal; out_valid ← 1.
  - Else on transfer: out_valid ← 0. Data fields hold their last value.
  - Else: hold.
- CC register: on accept with set_cc=1 and a legal op, cc_* ← the op's flags, at the same edge the output register loads. Otherwise cc_* hold.
- Flush:
  - Forces in_ready=0, so no accept.
  - out_valid ← 0 at the next edge, even if out_ready=0.
  - CC unchanged; data fields hold.
- Priority at each edge: rst > flush > accept > transfer.

## Timing
- Latency: 1 cycle. An op accepted at edge N is visible on result/out_valid after edge N, and its CC effect is visible after the same edge.
- Throughput: 1 op/cycle while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0 and every output holds stable.
- Reset, at the first rising edge with rst=1:
  - out_valid=0, result=0, res_zf=0, res_sf=0, res_of=0, illegal=0.
  - cc_zf=1, cc_sf=0, cc_of=0.
  - While rst=1, in_ready=0.
- Reset mid-operation discards the held result. No transfer is reported for it.
- Simultaneous transfer and accept in one cycle: the new op replaces the old one and out_valid stays 1. The downstream consumes the old value in that cycle.
- Flush together with out_ready=1 in one cycle: the held op is treated as consumed, and out_valid ← 0.

## Test plan
- Reset then idle:
  - Stimulus: assert rst for 2 cycles, then release.
  - Required: out_valid=0, cc = {zf=1, sf=0, of=0}, in_ready=1 in the first cycle after release.
- Arithmetic and overflow:
  - Stimulus: ADD 0x7FFF_FFFF_FFFF_FFFF + 1, with set_cc.
  - Required: result=0x8000_0000_0000_0000, SF=1, OF=1, ZF=0; cc updated one cycle after accept.
  - Stimulus: SUB 5 − 5.
  - Required: ZF=1, OF=0.
- Shifts:
  - SLL a=1, b=0xFFFF_FFFF_FFFF_FFC3 → 0x8.
  - SRA a=0x8000_0000_0000_0000, b=63 → 0xFFFF_FFFF_FFFF_FFFF.
  - SRL same operands → 0x1.
  - SLL a=0x1, b=64 → 0x1 (amount 0).
- Backpressure:
  - Stimulus: stream 4 back-to-back ops; hold out_ready=0 for 3 cycles mid-stream.
  - Required: in_ready=0 and result stable while stalled; all 4 results delivered in order with no loss or duplication.
- set_cc gating and illegal op:
  - Stimulus: op with set_cc=0 producing 0.
  - Required: cc unchanged.
  - Stimulus: alu_fun=7 with set_cc=1.
  - Required: illegal=1, result=0, cc unchanged.
- Flush and reset mid-stream:
  - Stimulus: flush while out_valid=1, out_ready=0, in_valid=1.
  - Required: input not accepted; out_valid=0 next cycle; cc unchanged.
  - Stimulus: rst asserted while out_valid=1.
  - Required: out_valid=0 next cycle.

Source files
------------

// File: rtl/alu_exec_if.sv
// Handshake and data bundle between decode, the ALU execute stage and memory/writeback.
// The master side issues operations and consumes results; the slave side is the execute stage.
interface alu_exec_if #(
  parameter int W = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_fun;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         set_cc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         res_zf;
  logic         res_sf;
  logic         res_of;
  logic         illegal;
  logic         cc_zf;
  logic         cc_sf;
  logic         cc_of;

  modport master (
    output in_valid, alu_fun, in_a, in_b, set_cc, out_ready,
    input  in_ready, out_valid, result, res_zf, res_sf, res_of, illegal,
           cc_zf, cc_sf, cc_of
  );

  modport slave (
    input  in_valid, alu_fun, in_a, in_b, set_cc, out_ready,
    output in_ready, out_valid, result, res_zf, res_sf, res_of, illegal,
           cc_zf, cc_sf, cc_of
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Registered 64-bit ALU execute stage: one op per cycle over valid/ready, a single output
// register carrying result and flags, and a condition-code register updated on request.
module alu_exec_stage #(
  parameter int W = 64
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  alu_exec_if.slave bus
);

  localparam logic [2:0] FUN_ADD = 3'd0;
  localparam logic [2:0] FUN_SUB = 3'd1;
  localparam logic [2:0] FUN_AND = 3'd2;
  localparam logic [2:0] FUN_XOR = 3'd3;
  localparam logic [2:0] FUN_SLL = 3'd4;
  localparam logic [2:0] FUN_SRL = 3'd5;
  localparam logic [2:0] FUN_SRA = 3'd6;

  logic [W-1:0] res_s;
  logic         of_s;
  logic         ill_s;
  logic         zf_s;
  logic [5:0]   shamt_s;
  logic         in_ready_s;
  logic         accept_s;
  logic         xfer_s;

  logic         out_valid_r;
  logic [W-1:0] result_r;
  logic         res_zf_r;
  logic         res_sf_r;
  logic         res_of_r;
  logic         illegal_r;
  logic         cc_zf_r;
  logic         cc_sf_r;
  logic         cc_of_r;

  // Signed overflow: ADD overflows when like-signed operands give an opposite-signed result,
  // SUB when unlike-signed operands give a result whose sign differs from a.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

  // Operation decode and evaluation
  always_comb begin
    res_s   = '0;
    of_s    = 1'b0;
    ill_s   = 1'b0;
    shamt_s = bus.in_b[5:0];
    case (bus.alu_fun)
      FUN_ADD: begin
        res_s = bus.in_a + bus.in_b;
        of_s  = add_ovf(bus.in_a[W-1], bus.in_b[W-1], res_s[W-1]);
      end
      FUN_SUB: begin
        res_s = bus.in_a - bus.in_b;
        of_s  = sub_ovf(bus.in_a[W-1], bus.in_b[W-1], res_s[W-1]);
      end
      FUN_AND: res_s = bus.in_a & bus.in_b;
      FUN_XOR: res_s = bus.in_a ^ bus.in_b;
      FUN_SLL: res_s = bus.in_a << shamt_s;
      FUN_SRL: res_s = bus.in_a >> shamt_s;
      FUN_SRA: res_s = $signed(bus.in_a) >>> shamt_s;
      default: ill_s = 1'b1;
    endcase
    zf_s = (res_s == '0);
  end

  // Handshake: accepting is allowed in the same cycle the held result drains
  always_comb begin
    in_ready_s = !rst && !flush && (!out_valid_r || bus.out_ready);
    accept_s   = bus.in_valid && in_ready_s;
    xfer_s     = out_valid_r && bus.out_ready;
  end

  // Output pipeline register and condition codes; priority rst > flush > accept > transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      result_r    <= '0;
      res_zf_r    <= 1'b0;
      res_sf_r    <= 1'b0;
      res_of_r    <= 1'b0;
      illegal_r   <= 1'b0;
      cc_zf_r     <= 1'b1;
      cc_sf_r     <= 1'b0;
      cc_of_r     <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      result_r    <= res_s;
      res_zf_r    <= zf_s;
      res_sf_r    <= res_s[W-1];
      res_of_r    <= of_s;
      illegal_r   <= ill_s;
      if (bus.set_cc && !ill_s) begin
        cc_zf_r <= zf_s;
        cc_sf_r <= res_s[W-1];
        cc_of_r <= of_s;
      end else begin
        cc_zf_r <= cc_zf_r;
        cc_sf_r <= cc_sf_r;
        cc_of_r <= cc_of_r;
      end
    end else if (xfer_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.res_zf    = res_zf_r;
  assign bus.res_sf    = res_sf_r;
  assign bus.res_of    = res_of_r;
  assign bus.illegal   = illegal_r;
  assign bus.cc_zf     = cc_zf_r;
  assign bus.cc_sf     = cc_sf_r;
  assign bus.cc_of     = cc_of_r;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed cases from the feature list followed by
// randomized traffic, all compared against a cycle-level behavioural model and result queue.
module tb_alu_exec_stage;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  alu_exec_if #(.W(64)) bus ();

  alu_exec_stage #(.W(64)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks     = 0;
  int failures   = 0;
  int deliveries = 0;

  logic        m_ov  = 1'b0;
  logic [63:0] m_res = 64'd0;
  logic [3:0]  m_fl  = 4'd0;
  logic [2:0]  m_cc  = 3'b100;
  logic [63:0] q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference semantics using exact 128-bit arithmetic; flags packed {zf, sf, of, illegal}
  function automatic void ref_op(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] r, output logic [3:0] fl);
    int unsigned  s;
    logic [127:0] wide;
    logic         of;
    logic         ill;
    s   = int'(b % 64);
    of  = 1'b0;
    ill = 1'b0;
    r   = 64'd0;
    case (f)
      3'd0: begin
        wide = {{64{a[63]}}, a} + {{64{b[63]}}, b};
        r    = wide[63:0];
        of   = (wide != {{64{r[63]}}, r});
      end
      3'd1: begin
        wide = {{64{a[63]}}, a} - {{64{b[63]}}, b};
        r    = wide[63:0];
        of   = (wide != {{64{r[63]}}, r});
      end
      3'd2: r = a & b;
      3'd3: r = a ^ b;
      3'd4: r = a << s;
      3'd5: r = a >> s;
      3'd6: begin
        wide = {{64{a[63]}}, a} >> s;
        r    = wide[63:0];
      end
      default: ill = 1'b1;
    endcase
    fl = {(r == 64'd0), r[63], of, ill};
  endfunction

  task automatic cycle();
    logic        rdy;
    logic [63:0] r;
    logic [3:0]  fl;
    #1;
    rdy = !rst && !flush && (!m_ov || bus.out_ready);
    chk("in_ready", 64'(bus.in_ready), 64'(rdy));
    if (!rst && m_ov && bus.out_ready) begin
      if (q.size() > 0) begin
        chk("deliver", bus.result, q.pop_front());
        deliveries++;
      end else begin
        chk("deliver_q", 64'(q.size()), 64'd1);
      end
    end
    if (rst || flush) q.delete();
    @(posedge clk);
    if (rst) begin
      m_ov  = 1'b0;
      m_res = 64'd0;
      m_fl  = 4'd0;
      m_cc  = 3'b100;
    end else if (flush) begin
      m_ov = 1'b0;
    end else if (bus.in_valid && rdy) begin
      ref_op(bus.alu_fun, bus.in_a, bus.in_b, r, fl);
      m_ov  = 1'b1;
      m_res = r;
      m_fl  = fl;
      q.push_back(r);
      if (bus.set_cc && bus.alu_fun != 3'd7) m_cc = fl[3:1];
    end else if (m_ov && bus.out_ready) begin
      m_ov = 1'b0;
    end
    #1;
    chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
    chk("result", bus.result, m_res);
    chk("flags", 64'({bus.res_zf, bus.res_sf, bus.res_of, bus.illegal}), 64'(m_fl));
    chk("cc", 64'({bus.cc_zf, bus.cc_sf, bus.cc_of}), 64'(m_cc));
  endtask

  task automatic op(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b, input logic sc);
    bus.in_valid  = 1'b1;
    bus.alu_fun   = f;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.set_cc    = sc;
    bus.out_ready = 1'b1;
    cycle();
    bus.in_valid  = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    case ($urandom_range(0, 5))
      0: v = 64'h7FFF_FFFF_FFFF_FFFF;
      1: v = 64'h8000_0000_0000_0000;
      2: v = 64'(v[7:0]);
      default: v = v;
    endcase
    return v;
  endfunction

  initial begin
    logic [2:0]  cc_save;
    logic [63:0] sa[4];
    logic [63:0] sb[4];
    logic [2:0]  sf[4];
    int          d0;

    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_fun   = 3'd0;
    bus.in_a      = 64'd0;
    bus.in_b      = 64'd0;
    bus.set_cc    = 1'b0;
    bus.out_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_cc", 64'({bus.cc_zf, bus.cc_sf, bus.cc_of}), 64'(3'b100));
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    cycle();

    op(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    chk("add_ovf_res", bus.result, 64'h8000_0000_0000_0000);
    chk("add_ovf_flags", 64'({bus.res_zf, bus.res_sf, bus.res_of}), 64'(3'b011));
    chk("add_ovf_cc", 64'({bus.cc_zf, bus.cc_sf, bus.cc_of}), 64'(3'b011));

    op(3'd1, 64'd5, 64'd5, 1'b0);
    chk("sub_zero_flags", 64'({bus.res_zf, bus.res_of}), 64'(2'b10));
    chk("sub_nocc", 64'({bus.cc_zf, bus.cc_sf, bus.cc_of}), 64'(3'b011));

    op(3'd4, 64'd1, 64'hFFFF_FFFF_FFFF_FFC3, 1'b0);
    chk("sll_amt", bus.result, 64'h8);
    op(3'd6, 64'h8000_0000_0000_0000, 64'd63, 1'b0);
    chk("sra_63", bus.result, 64'hFFFF_FFFF_FFFF_FFFF);
    op(3'd5, 64'h8000_0000_0000_0000, 64'd63, 1'b0);
    chk("srl_63", bus.result, 64'h1);
    op(3'd4, 64'd1, 64'd64, 1'b0);
    chk("sll_64", bus.result, 64'h1);

    op(3'd7, rnd64(), rnd64(), 1'b1);
    chk("ill_flag", 64'(bus.illegal), 64'd1);
    chk("ill_res", bus.result, 64'd0);
    chk("ill_cc", 64'({bus.cc_zf, bus.cc_sf, bus.cc_of}), 64'(3'b011));

    // Drain, then stream four ops with a three-cycle stall on the third
    bus.out_ready = 1'b1;
    cycle();
    d0 = deliveries;
    for (int i = 0; i < 4; i++) begin
      sf[i] = 3'($urandom_range(0, 6));
      sa[i] = rnd64();
      sb[i] = rnd64();
    end
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.alu_fun  = sf[i];
      bus.in_a     = sa[i];
      bus.in_b     = sb[i];
      bus.set_cc   = 1'b1;
      if (i == 2) begin
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          cycle();
          chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
      end
      bus.out_ready = 1'b1;
      cycle();
    end
    bus.in_valid = 1'b0;
    cycle();
    chk("bp_count", 64'(deliveries - d0), 64'd4);

    op(3'd3, rnd64(), rnd64(), 1'b0);
    cc_save       = m_cc;
    bus.in_valid  = 1'b1;
    bus.set_cc    = 1'b1;
    bus.out_ready = 1'b0;
    flush         = 1'b1;
    cycle();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_ov", 64'(bus.out_valid), 64'd0);
    chk("flush_cc", 64'({bus.cc_zf, bus.cc_sf, bus.cc_of}), 64'(cc_save));

    op(3'd0, rnd64(), rnd64(), 1'b1);
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_mid_ov", 64'(bus.out_valid), 64'd0);

    for (int n = 0; n < 400; n++) begin
      rst           = ($urandom_range(0, 99) == 0);
      flush         = ($urandom_range(0, 19) == 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.alu_fun   = 3'($urandom_range(0, 7));
      bus.in_a      = rnd64();
      bus.in_b      = rnd64();
      bus.set_cc    = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
